// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one registered WIDTH-bit adder between NUM_REQ requesters.
// Results come back with the winner's ID on a valid/ready port; op_count tallies drained responses.
module adder_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 8,
    parameter  int CNT_W   = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry,
    output logic [CNT_W-1:0]         op_count
);

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               rspValid_q, rspValid_d;
    logic [ID_W-1:0]    rspId_q, rspId_d;
    logic [WIDTH-1:0]   rspSum_q, rspSum_d;
    logic               rspCarry_q, rspCarry_d;
    logic [CNT_W-1:0]   opCount_q, opCount_d;

    logic [NUM_REQ-1:0] grant;
    logic               found;
    logic [ID_W-1:0]    winId;
    logic [WIDTH-1:0]   winA, winB;
    logic               slotFree;
    logic               accept;
    logic               drain;
    logic [WIDTH:0]     fullSum;

    assign slotFree  = !rspValid_q || rsp_ready;
    assign req_ready = (rst_n && slotFree) ? grant : '0;
    assign accept    = |req_ready;
    assign drain     = rspValid_q && rsp_ready;
    assign fullSum   = {1'b0, winA} + {1'b0, winB};

    // Search from the pointer upward, wrapping, for the first valid requester.
    always_comb begin
        int idx;
        grant = '0;
        found = 1'b0;
        winId = '0;
        winA  = '0;
        winB  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winId      = ID_W'(idx);
                winA       = req_a[idx*WIDTH +: WIDTH];
                winB       = req_b[idx*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        rspValid_d = rspValid_q;
        rspId_d    = rspId_q;
        rspSum_d   = rspSum_q;
        rspCarry_d = rspCarry_q;
        opCount_d  = drain ? opCount_q + 1'b1 : opCount_q;
        if (accept) begin
            rspValid_d = 1'b1;
            rspId_d    = winId;
            rspSum_d   = fullSum[WIDTH-1:0];
            rspCarry_d = fullSum[WIDTH];
            ptr_d      = (winId == ID_W'(NUM_REQ - 1)) ? '0 : winId + 1'b1;
        end else if (drain) begin
            rspValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            rspValid_q <= 1'b0;
            rspId_q    <= '0;
            rspSum_q   <= '0;
            rspCarry_q <= 1'b0;
            opCount_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rspValid_q <= rspValid_d;
            rspId_q    <= rspId_d;
            rspSum_q   <= rspSum_d;
            rspCarry_q <= rspCarry_d;
            opCount_q  <= opCount_d;
        end
    end

    assign rsp_valid = rspValid_q;
    assign rsp_id    = rspId_q;
    assign rsp_sum   = rspSum_q;
    assign rsp_carry = rspCarry_q;
    assign op_count  = opCount_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Testbench for adder_rr_arbiter: directed scenarios plus random traffic,
// every cycle compared against a queue-free behavioural model of the arbiter.
module tb_adder_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int C  = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rstN;
    logic [N-1:0]   reqValid;
    logic [N*W-1:0] reqA, reqB;
    logic [N-1:0]   reqReady;
    logic           rspValid;
    logic           rspReady;
    logic [IW-1:0]  rspId;
    logic [W-1:0]   rspSum;
    logic           rspCarry;
    logic [C-1:0]   opCount;

    int total = 0;
    int bad   = 0;

    int mValid, mId, mSum, mCarry, mCnt, mPtr;

    always #5 clk = ~clk;

    adder_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .rst_n(rstN),
        .req_valid(reqValid), .req_a(reqA), .req_b(reqB), .req_ready(reqReady),
        .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_id(rspId),
        .rsp_sum(rspSum), .rsp_carry(rspCarry), .op_count(opCount)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected grant index from the model, or -1 when nobody may be granted
    function automatic int expWinner();
        if (!rstN) return -1;
        if (mValid != 0 && !rspReady) return -1;
        for (int k = 0; k < N; k++) begin
            if (reqValid[(mPtr + k) % N]) return (mPtr + k) % N;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic r, input logic [N-1:0] v,
                                 input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                                 input logic rr);
        int win;
        int s;
        logic [N-1:0] expReady;
        @(negedge clk);
        rstN     = r;
        reqValid = v;
        reqA     = a;
        reqB     = b;
        rspReady = rr;
        #1;
        win      = expWinner();
        expReady = (win < 0) ? '0 : N'(1 << win);
        checkOutput("req_ready", 32'(reqReady), 32'(expReady));
        checkOutput("rsp_valid", 32'(rspValid), mValid);
        checkOutput("rsp_id",    32'(rspId),    mId);
        checkOutput("rsp_sum",   32'(rspSum),   mSum);
        checkOutput("rsp_carry", 32'(rspCarry), mCarry);
        checkOutput("op_count",  32'(opCount),  mCnt);
        @(posedge clk);
        if (!r) begin
            mValid = 0; mId = 0; mSum = 0; mCarry = 0; mCnt = 0; mPtr = 0;
        end else begin
            if (mValid != 0 && rr) begin
                mCnt = (mCnt + 1) % (1 << C);
                mValid = 0;
            end
            if (win >= 0) begin
                s      = int'(a[win*W +: W]) + int'(b[win*W +: W]);
                mValid = 1;
                mId    = win;
                mSum   = s % (1 << W);
                mCarry = s >> W;
                mPtr   = (win + 1) % N;
            end
        end
    endtask

    initial begin
        logic [N*W-1:0] ra, rb;
        mValid = 0; mId = 0; mSum = 0; mCarry = 0; mCnt = 0; mPtr = 0;
        rstN = 1'b0; reqValid = '0; reqA = '0; reqB = '0; rspReady = 1'b0;

        // Reset held with every request asserted, then the first grant goes to 0
        @(posedge clk);
        applyStimulus(1'b0, 4'hF, 32'h0403_0201, 32'h0101_0101, 1'b1);
        applyStimulus(1'b0, 4'hF, 32'h0403_0201, 32'h0101_0101, 1'b1);
        #1;
        checkOutput("reset_rsp_valid", 32'(rspValid), 0);
        checkOutput("reset_op_count",  32'(opCount), 0);
        applyStimulus(1'b1, 4'hF, 32'h0403_0201, 32'h0101_0101, 1'b1);
        #1;
        checkOutput("first_grant_id", 32'(rspId), 0);

        // Single op with carry out from requester 2
        applyStimulus(1'b1, 4'b0100, 32'h00F0_0000, 32'h0020_0000, 1'b1);
        #1;
        checkOutput("single_valid", 32'(rspValid), 1);
        checkOutput("single_id",    32'(rspId),    2);
        checkOutput("single_sum",   32'(rspSum),   32'h10);
        checkOutput("single_carry", 32'(rspCarry), 1);

        // Round-robin order 0,1,2,3,0,1 with full throughput
        applyStimulus(1'b0, 4'h0, '0, '0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 4'hF, 32'h8040_2010, 32'h0807_0605, 1'b1);
            #1;
            checkOutput("rr_order", 32'(rspId), k % N);
        end
        applyStimulus(1'b1, 4'h0, '0, '0, 1'b1);
        #1;
        checkOutput("rr_op_count", 32'(opCount), 6);

        // Back-pressure: pending result is held and no grants are issued
        applyStimulus(1'b1, 4'hF, 32'h1122_3344, 32'h5566_7788, 1'b1);
        #1;
        ra[7:0] = rspSum;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        end
        #1;
        checkOutput("bp_sum_stable", 32'(rspSum), 32'(ra[7:0]));
        applyStimulus(1'b1, 4'hF, 32'h0102_0304, 32'h0102_0304, 1'b1);

        // Pointer wrap: park pointer at 3, then only requester 1 is valid
        applyStimulus(1'b0, 4'h0, '0, '0, 1'b1);
        applyStimulus(1'b1, 4'b0100, 32'h0011_0000, 32'h0022_0000, 1'b1);
        applyStimulus(1'b1, 4'b0010, 32'h0000_AA00, 32'h0000_6600, 1'b1);
        #1;
        checkOutput("wrap_id",  32'(rspId),  1);
        checkOutput("wrap_sum", 32'(rspSum), 32'h10);
        applyStimulus(1'b1, 4'hF, 32'h0405_0607, 32'h0000_0000, 1'b1);
        #1;
        checkOutput("wrap_next_ptr", 32'(rspId), 2);

        // Counter wrap 8'hFF -> 8'h00
        applyStimulus(1'b0, 4'h0, '0, '0, 1'b1);
        for (int k = 0; k < 256; k++) begin
            applyStimulus(1'b1, 4'hF, 32'(k), 32'(k * 3), 1'b1);
        end
        #1;
        checkOutput("cnt_ff", 32'(opCount), 32'hFF);
        applyStimulus(1'b1, 4'hF, 32'h0, 32'h0, 1'b1);
        #1;
        checkOutput("cnt_wrap", 32'(opCount), 0);

        // Reset while a response is stalled
        applyStimulus(1'b1, 4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        applyStimulus(1'b1, 4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        applyStimulus(1'b0, 4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        #1;
        checkOutput("midrst_valid", 32'(rspValid), 0);
        checkOutput("midrst_cnt",   32'(opCount),  0);
        applyStimulus(1'b1, 4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        #1;
        checkOutput("midrst_grant", 32'(rspId), 0);

        // Random traffic with occasional resets and back-pressure
        for (int k = 0; k < 2000; k++) begin
            ra = $urandom;
            rb = $urandom;
            applyStimulus(($urandom_range(0, 49) != 0), N'($urandom),
                          ra, rb, ($urandom_range(0, 3) != 0));
        end
        applyStimulus(1'b1, 4'h0, '0, '0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
